// File: rtl/bram_fifo_ctrl_if.sv
// Stream bundle between a producer/consumer and the BRAM FIFO controller.
//
// Handshake: a transfer happens on a rising clk edge where vld and rdy are
// both high. The sender holds vld high and its data stable until that
// edge, and never waits for rdy before raising vld. The receiver may drive
// rdy independently of vld.
//
// Signals:
//   wr_vld / wr_dat / wr_rdy : write stream into the FIFO
//   rd_vld / rd_dat / rd_rdy : first-word-fall-through stream out of the FIFO
// Modports:
//   master : the side that feeds writes and accepts reads (the user)
//   slave  : the FIFO controller itself
interface bram_fifo_ctrl_if #(
  parameter int DAT = 9
);
  logic           wr_vld;
  logic [DAT-1:0] wr_dat;
  logic           wr_rdy;
  logic           rd_vld;
  logic [DAT-1:0] rd_dat;
  logic           rd_rdy;

  modport master (
    output wr_vld, wr_dat, rd_rdy,
    input  wr_rdy, rd_vld, rd_dat
  );

  modport slave (
    input  wr_vld, wr_dat, rd_rdy,
    output wr_rdy, rd_vld, rd_dat
  );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// Single-clock FIFO controller driving an external dual-port block RAM.
// Port A writes, port B reads. Reads are tracked through a RAM latency of
// DEL cycles (1 or 2) and land in a small registered output buffer that
// presents a first-word-fall-through stream.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : synchronous clear of all contents (beats writes and reads)
//   s         : stream bundle (slave modport): wr_vld/wr_dat/wr_rdy in,
//               rd_vld/rd_dat/rd_rdy out
//   level     : registered count of words held (RAM + in flight + buffer)
//   ram_adra, ram_wena, ram_rena, ram_wdaa : RAM port A (write)
//   ram_wenb (tied 0), ram_adrb, ram_renb, ram_rdab : RAM port B (read)
module bram_fifo_ctrl #(
  parameter int ADR = 8,
  parameter int DAT = 9,
  parameter int DEP = 256,
  parameter int DEL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  bram_fifo_ctrl_if.slave s,
  output logic [ADR:0]    level,
  output logic [ADR-1:0]  ram_adra,
  output logic            ram_wena,
  output logic            ram_rena,
  output logic [DAT-1:0]  ram_wdaa,
  output logic            ram_wenb,
  output logic [ADR-1:0]  ram_adrb,
  output logic            ram_renb,
  input  logic [DAT-1:0]  ram_rdab
);

  localparam int OBN = DEL + 1;             // output buffer entries
  localparam int OBW = $clog2(OBN + 1);     // width of an entry count
  localparam int IW  = $clog2(OBN);         // width of a buffer index
  localparam int BW  = OBW + 1;             // in flight + buffered sum
  localparam int CW  = ADR + 1;             // ram_cnt / level width

  logic [ADR-1:0] wptr, wptr_nxt;
  logic [ADR-1:0] rptr, rptr_nxt;
  logic [CW-1:0]  ram_cnt, ram_cnt_nxt;
  logic [DEL-1:0] infl, infl_nxt;
  logic [OBW-1:0] infl_cnt;
  logic [DAT-1:0] ob_mem [OBN];
  logic [IW-1:0]  ob_head, ob_head_nxt;
  logic [IW-1:0]  ob_tail, ob_tail_nxt;
  logic [OBW-1:0] ob_cnt, ob_cnt_nxt;
  logic [CW-1:0]  level_nxt;
  logic [BW-1:0]  busy;
  logic           wr_acc, rd_iss, push, pop;

  function automatic logic [ADR-1:0] wrap_adr(input logic [ADR-1:0] p);
    return (p == ADR'(DEP - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [IW-1:0] wrap_ob(input logic [IW-1:0] p);
    return (p == IW'(OBN - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [OBW-1:0] ones(input logic [DEL-1:0] v);
    logic [OBW-1:0] n;
    n = '0;
    for (int i = 0; i < DEL; i++) n = n + OBW'(v[i]);
    return n;
  endfunction

  // wr_rdy looks only at registered ram_cnt, so a read issued while full
  // frees space one cycle later. Forced low while rst is held.
  assign s.wr_rdy = !rst && (ram_cnt < CW'(DEP));
  assign s.rd_vld = (ob_cnt != '0);
  assign s.rd_dat = ob_mem[ob_head];

  assign infl_cnt = ones(infl);

  assign ram_adra = wptr;
  assign ram_wdaa = s.wr_dat;
  assign ram_wena = wr_acc;
  assign ram_rena = wr_acc;
  assign ram_wenb = 1'b0;
  assign ram_adrb = rptr;
  assign ram_renb = rd_iss;

  always_comb begin
    wr_acc = s.wr_vld && s.wr_rdy && !flush;
    pop    = s.rd_vld && s.rd_rdy && !flush;
    // The tail of the in-flight pipe marks ram_rdab valid this cycle.
    push   = infl[DEL-1] && !flush;

    // Read credit: in-flight words plus buffered words must leave room in
    // the DEL+1 entry buffer. A word leaving the buffer this cycle frees
    // its slot, which is what lets the stream run at one word per cycle.
    busy   = BW'(infl_cnt) + BW'(ob_cnt) - BW'(s.rd_vld && s.rd_rdy);
    rd_iss = !flush && (ram_cnt != '0) && (busy < BW'(OBN));

    wptr_nxt    = wr_acc ? wrap_adr(wptr) : wptr;
    rptr_nxt    = rd_iss ? wrap_adr(rptr) : rptr;
    ram_cnt_nxt = ram_cnt;
    case ({wr_acc, rd_iss})
      2'b10:   ram_cnt_nxt = ram_cnt + 1'b1;
      2'b01:   ram_cnt_nxt = ram_cnt - 1'b1;
      default: ram_cnt_nxt = ram_cnt;
    endcase
    infl_nxt    = (infl << 1) | DEL'(rd_iss);
    ob_tail_nxt = push ? wrap_ob(ob_tail) : ob_tail;
    ob_head_nxt = pop ? wrap_ob(ob_head) : ob_head;
    ob_cnt_nxt  = ob_cnt + OBW'(push) - OBW'(pop);

    // Clearing the in-flight pipe is what discards late RAM returns.
    if (flush) begin
      wptr_nxt    = '0;
      rptr_nxt    = '0;
      ram_cnt_nxt = '0;
      infl_nxt    = '0;
      ob_tail_nxt = '0;
      ob_head_nxt = '0;
      ob_cnt_nxt  = '0;
    end

    level_nxt = ram_cnt_nxt + CW'(ones(infl_nxt)) + CW'(ob_cnt_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      infl    <= '0;
      ob_head <= '0;
      ob_tail <= '0;
      ob_cnt  <= '0;
      level   <= '0;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      ram_cnt <= ram_cnt_nxt;
      infl    <= infl_nxt;
      ob_head <= ob_head_nxt;
      ob_tail <= ob_tail_nxt;
      ob_cnt  <= ob_cnt_nxt;
      level   <= level_nxt;
    end
  end

  // Buffer storage needs no reset; ob_cnt alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) ob_mem[ob_tail] <= ram_rdab;
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: two instances share one stimulus stream,
// u1 with DEP=8/DEL=1 and u2 with DEP=5/DEL=2, each with its own RAM model
// and expected-data queue.
module tb_bram_fifo_ctrl;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic flush;
  logic wr_vld;
  logic rd_rdy;
  logic [8:0] wr_dat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and RAM models ----------------
  bram_fifo_ctrl_if #(.DAT(9)) if1 ();
  bram_fifo_ctrl_if #(.DAT(9)) if2 ();

  assign if1.wr_vld = wr_vld;
  assign if1.wr_dat = wr_dat;
  assign if1.rd_rdy = rd_rdy;
  assign if2.wr_vld = wr_vld;
  assign if2.wr_dat = wr_dat;
  assign if2.rd_rdy = rd_rdy;

  logic [8:0] level1;
  logic [7:0] adra1, adrb1;
  logic       wena1, rena1, wenb1, renb1;
  logic [8:0] wdaa1, rdab1;

  logic [3:0] level2;
  logic [2:0] adra2, adrb2;
  logic       wena2, rena2, wenb2, renb2;
  logic [8:0] wdaa2, rdab2, p2;

  bram_fifo_ctrl #(.ADR(8), .DAT(9), .DEP(8), .DEL(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .s(if1), .level(level1),
    .ram_adra(adra1), .ram_wena(wena1), .ram_rena(rena1), .ram_wdaa(wdaa1),
    .ram_wenb(wenb1), .ram_adrb(adrb1), .ram_renb(renb1), .ram_rdab(rdab1)
  );

  bram_fifo_ctrl #(.ADR(3), .DAT(9), .DEP(5), .DEL(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .s(if2), .level(level2),
    .ram_adra(adra2), .ram_wena(wena2), .ram_rena(rena2), .ram_wdaa(wdaa2),
    .ram_wenb(wenb2), .ram_adrb(adrb2), .ram_renb(renb2), .ram_rdab(rdab2)
  );

  logic [8:0] mem1 [256];
  logic [8:0] mem2 [8];

  always @(posedge clk) begin
    if (wena1) mem1[adra1] <= wdaa1;
    if (renb1) rdab1 <= mem1[adrb1];
  end

  always @(posedge clk) begin
    if (wena2) mem2[adra2] <= wdaa2;
    if (renb2) p2 <= mem2[adrb2];
    rdab2 <= p2;
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboards ----------------
  logic [8:0] exp1_q[$];
  logic [8:0] exp2_q[$];

  always @(negedge clk) begin
    if (rst) exp1_q.delete();
    else begin
      chk("level1", 32'(level1), 32'(exp1_q.size()));
      if (flush) exp1_q.delete();
      else begin
        if (if1.rd_vld && rd_rdy) begin
          if (exp1_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pop1: actual pop with rd_dat 0x%0h, required no word", if1.rd_dat);
          end else chk("rd_dat1", 32'(if1.rd_dat), 32'(exp1_q.pop_front()));
        end
        if (wr_vld && if1.wr_rdy) exp1_q.push_back(wr_dat);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) exp2_q.delete();
    else begin
      chk("level2", 32'(level2), 32'(exp2_q.size()));
      if (flush) exp2_q.delete();
      else begin
        if (if2.rd_vld && rd_rdy) begin
          if (exp2_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pop2: actual pop with rd_dat 0x%0h, required no word", if2.rd_dat);
          end else chk("rd_dat2", 32'(if2.rd_dat), 32'(exp2_q.pop_front()));
        end
        if (wr_vld && if2.wr_rdy) exp2_q.push_back(wr_dat);
      end
    end
  end

  // ---------------- vectors ----------------
  // One row per cycle: inputs, then wr_rdy/level of each instance after the edge.
  typedef struct {
    logic       wr_vld;
    logic [8:0] wr_dat;
    logic       rd_rdy;
    logic       rdy1;
    int         lvl1;
    logic       rdy2;
    int         lvl2;
  } vec_t;

  vec_t tbl[12];
  int wp_tab[8] = '{9, 5, 2, 9, 7, 3, 9, 5};
  int rp_tab[8] = '{2, 5, 9, 9, 3, 7, 5, 9};

  task automatic drain();
    wr_vld = 1'b0;
    rd_rdy = 1'b1;
    repeat (24) tick();
    chk("drain_level1", 32'(level1), 32'd0);
    chk("drain_level2", 32'(level2), 32'd0);
    rd_rdy = 1'b0;
  endtask

  initial begin
    logic prev1, prev2;

    tbl[0]  = '{1'b1, 9'h001, 1'b0, 1'b1,  1, 1'b1, 1};
    tbl[1]  = '{1'b1, 9'h002, 1'b0, 1'b1,  2, 1'b1, 2};
    tbl[2]  = '{1'b1, 9'h003, 1'b0, 1'b1,  3, 1'b1, 3};
    tbl[3]  = '{1'b1, 9'h004, 1'b0, 1'b1,  4, 1'b1, 4};
    tbl[4]  = '{1'b1, 9'h005, 1'b0, 1'b1,  5, 1'b1, 5};
    tbl[5]  = '{1'b1, 9'h006, 1'b0, 1'b1,  6, 1'b1, 6};
    tbl[6]  = '{1'b1, 9'h007, 1'b0, 1'b1,  7, 1'b1, 7};
    tbl[7]  = '{1'b1, 9'h008, 1'b0, 1'b1,  8, 1'b0, 8};
    tbl[8]  = '{1'b1, 9'h009, 1'b0, 1'b1,  9, 1'b0, 8};
    tbl[9]  = '{1'b1, 9'h00A, 1'b0, 1'b0, 10, 1'b0, 8};
    tbl[10] = '{1'b1, 9'h00B, 1'b0, 1'b0, 10, 1'b0, 8};
    tbl[11] = '{1'b1, 9'h00C, 1'b0, 1'b0, 10, 1'b0, 8};

    rst = 1'b1;
    flush = 1'b0;
    wr_vld = 1'b0;
    rd_rdy = 1'b0;
    wr_dat = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // Reset state.
    chk("rst_wr_rdy1", 32'(if1.wr_rdy), 32'd1);
    chk("rst_wr_rdy2", 32'(if2.wr_rdy), 32'd1);
    chk("rst_rd_vld1", 32'(if1.rd_vld), 32'd0);
    chk("rst_rd_vld2", 32'(if2.rd_vld), 32'd0);
    chk("rst_level1", 32'(level1), 32'd0);
    chk("rst_level2", 32'(level2), 32'd0);
    chk("rst_wena1", 32'(wena1), 32'd0);
    chk("rst_renb1", 32'(renb1), 32'd0);
    chk("rst_renb2", 32'(renb2), 32'd0);
    chk("rst_wenb1", 32'(wenb1), 32'd0);
    chk("rst_wenb2", 32'(wenb2), 32'd0);

    // Fill with reads stalled: u1 takes 10, u2 takes 8.
    prev1 = 1'b1;
    prev2 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      wr_vld = tbl[k].wr_vld;
      wr_dat = tbl[k].wr_dat;
      rd_rdy = tbl[k].rd_rdy;
      #1;
      chk($sformatf("fill_wena1_%0d", k), 32'(wena1), 32'(wr_vld && prev1));
      chk($sformatf("fill_rena1_%0d", k), 32'(rena1), 32'(wr_vld && prev1));
      chk($sformatf("fill_wena2_%0d", k), 32'(wena2), 32'(wr_vld && prev2));
      tick();
      chk($sformatf("fill_wr_rdy1_%0d", k), 32'(if1.wr_rdy), 32'(tbl[k].rdy1));
      chk($sformatf("fill_level1_%0d", k), 32'(level1), 32'(tbl[k].lvl1));
      chk($sformatf("fill_wr_rdy2_%0d", k), 32'(if2.wr_rdy), 32'(tbl[k].rdy2));
      chk($sformatf("fill_level2_%0d", k), 32'(level2), 32'(tbl[k].lvl2));
      prev1 = tbl[k].rdy1;
      prev2 = tbl[k].rdy2;
    end
    drain();

    // Latency of a single word into an empty FIFO.
    wr_vld = 1'b1;
    wr_dat = 9'h1A5;
    tick();
    wr_vld = 1'b0;
    chk("lat_e0_vld1", 32'(if1.rd_vld), 32'd0);
    chk("lat_e0_vld2", 32'(if2.rd_vld), 32'd0);
    tick();
    chk("lat_e1_vld1", 32'(if1.rd_vld), 32'd0);
    chk("lat_e1_vld2", 32'(if2.rd_vld), 32'd0);
    tick();
    chk("lat_e2_vld1", 32'(if1.rd_vld), 32'd1);
    chk("lat_e2_dat1", 32'(if1.rd_dat), 32'h1A5);
    chk("lat_e2_vld2", 32'(if2.rd_vld), 32'd0);
    tick();
    chk("lat_e3_vld2", 32'(if2.rd_vld), 32'd1);
    chk("lat_e3_dat2", 32'(if2.rd_dat), 32'h1A5);
    drain();

    // Continuous stream: one in and one out per cycle once primed.
    rd_rdy = 1'b1;
    for (int k = 0; k < 100; k++) begin
      wr_vld = 1'b1;
      wr_dat = 9'(k + 16);
      tick();
      if (k >= 3) begin
        chk($sformatf("strm_level1_%0d", k), 32'(level1), 32'd3);
        chk($sformatf("strm_level2_%0d", k), 32'(level2), 32'd4);
        chk($sformatf("strm_vld1_%0d", k), 32'(if1.rd_vld), 32'd1);
        chk($sformatf("strm_vld2_%0d", k), 32'(if2.rd_vld), 32'd1);
      end
    end
    drain();

    // Flush with words in RAM, in flight and buffered.
    for (int k = 0; k < 4; k++) begin
      wr_vld = 1'b1;
      wr_dat = 9'(9'h0A1 + k);
      tick();
    end
    flush = 1'b1;
    wr_dat = 9'h0EE;
    #1;
    chk("flush_wena1", 32'(wena1), 32'd0);
    chk("flush_wena2", 32'(wena2), 32'd0);
    tick();
    flush = 1'b0;
    wr_vld = 1'b0;
    chk("flush_level1", 32'(level1), 32'd0);
    chk("flush_level2", 32'(level2), 32'd0);
    chk("flush_wr_rdy1", 32'(if1.wr_rdy), 32'd1);
    chk("flush_wr_rdy2", 32'(if2.wr_rdy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("flush_vld1_%0d", k), 32'(if1.rd_vld), 32'd0);
      chk($sformatf("flush_vld2_%0d", k), 32'(if2.rd_vld), 32'd0);
      tick();
    end
    wr_vld = 1'b1;
    wr_dat = 9'h055;
    tick();
    wr_vld = 1'b0;
    repeat (4) tick();
    chk("post_flush_vld1", 32'(if1.rd_vld), 32'd1);
    chk("post_flush_dat1", 32'(if1.rd_dat), 32'h055);
    chk("post_flush_vld2", 32'(if2.rd_vld), 32'd1);
    chk("post_flush_dat2", 32'(if2.rd_dat), 32'h055);
    drain();

    // Asynchronous reset mid-stream.
    wr_vld = 1'b1;
    rd_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wr_dat = 9'($urandom_range(0, 511));
      tick();
    end
    #1 rst = 1'b1;
    #1;
    chk("arst_vld1", 32'(if1.rd_vld), 32'd0);
    chk("arst_vld2", 32'(if2.rd_vld), 32'd0);
    chk("arst_level1", 32'(level1), 32'd0);
    chk("arst_level2", 32'(level2), 32'd0);
    chk("arst_wr_rdy1", 32'(if1.wr_rdy), 32'd0);
    chk("arst_wr_rdy2", 32'(if2.wr_rdy), 32'd0);
    chk("arst_wena1", 32'(wena1), 32'd0);
    chk("arst_renb2", 32'(renb2), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    wr_vld = 1'b1;
    wr_dat = 9'h0C3;
    rd_rdy = 1'b0;
    #1;
    chk("rel_wena1", 32'(wena1), 32'd1);
    chk("rel_adra1", 32'(adra1), 32'd0);
    chk("rel_wena2", 32'(wena2), 32'd1);
    chk("rel_adra2", 32'(adra2), 32'd0);
    tick();
    wr_vld = 1'b0;
    #1;
    chk("rel_renb1", 32'(renb1), 32'd1);
    chk("rel_adrb1", 32'(adrb1), 32'd0);
    chk("rel_renb2", 32'(renb2), 32'd1);
    chk("rel_adrb2", 32'(adrb2), 32'd0);
    repeat (4) tick();
    chk("rel_dat1", 32'(if1.rd_dat), 32'h0C3);
    chk("rel_dat2", 32'(if2.rd_dat), 32'h0C3);
    drain();

    // Random traffic, with write/read pressure varied in phases.
    for (int i = 0; i < 10000; i++) begin
      wr_vld = ($urandom_range(0, 9) < wp_tab[(i / 1250) % 8]);
      rd_rdy = ($urandom_range(0, 9) < rp_tab[(i / 1250) % 8]);
      wr_dat = 9'($urandom_range(0, 511));
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
